universal_shift_reg: RTL and testbench
======================================

// Module: universal_shift_reg
// PURPOSE
//  Parametrised successor to the single-bit SISO shifter. It supports hold, shift right,
//  shift left and parallel load, with serial and parallel I/O and a saturating shift counter.
//  A full flag asserts once a whole word has been shifted in since the last load or reset.
//  Used as the common SISO/SIPO/PISO/PIPO building block for serial links and test chains.
// PARAMETERS
//  WIDTH      8     register length in bits (>=2)
//  RESET_VAL  0     value loaded into the register on reset (WIDTH bits)
// PORTS
//  clk    in   1                 rising-edge clock
//  reset  in   1                 asynchronous, active-high reset
//  en     in   1                 shift/load enable; 0 = hold everything
//  mode   in   2                 00 hold, 01 shift right, 10 shift left, 11 parallel load
//  din    in   1                 serial data in (enters MSB on right shift, LSB on left shift)
//  pin    in   WIDTH             parallel load data
//  rot    in   1                 rotate select (present only with SHIFT_ROTATE_EN)
//  qout   out  1                 serial out: q[0] if last shift dir=right, q[WIDTH-1] if left
//  pout   out  WIDTH             register contents
//  cnt    out  $clog2(WIDTH+1)   shifts since last load/reset, saturates at WIDTH
//  full   out  1                 1 when cnt==WIDTH
// BEHAVIOUR
//  - Reset (async, immediate): q=RESET_VAL, cnt=0, full=0, dir=right (qout=RESET_VAL[0]).
//  - All updates occur on the rising clk edge when en=1. When en=0, state holds regardless of mode.
//  - mode 00: hold; q, cnt and dir are unchanged.
//  - mode 01: q <= {din, q[WIDTH-1:1]}; dir <= right; cnt <= min(cnt+1, WIDTH).
//  - mode 10: q <= {q[WIDTH-2:0], din}; dir <= left; cnt <= min(cnt+1, WIDTH).
//  - mode 11: q <= pin; cnt <= 0; dir is unchanged.
//  - pout, cnt and full are registered state with no combinational path from inputs.
//    qout is a mux of q selected by the registered dir, so it changes only on a clk edge or reset.
//  - Latency: a bit on din appears at qout after WIDTH enabled shifts in the same direction.
//    Load-to-qout latency is 1 clk.
//  - Counter: saturates at WIDTH and never wraps. full is 1 exactly when cnt==WIDTH.
//    Further shifts with full=1 keep cnt=WIDTH and keep shifting data.
//  - Direction change mid-word: data shifts as specified, cnt keeps counting (it is not cleared),
//    and qout switches end on the next edge.
//  - Reset asserted mid-shift overrides everything. The first edge after deassert acts normally.
// CONFIGURATION
//  SHIFT_ROTATE_EN defined:
//    - The rot port exists.
//    - In modes 01/10 with rot=1, the bit shifted out is fed back instead of din:
//      right gives {q[0], q[WIDTH-1:1]}, left gives {q[WIDTH-2:0], q[WIDTH-1]}.
//    - cnt still increments and dir updates as for a normal shift.
//    - Load and hold are unaffected by rot.
//  SHIFT_ROTATE_EN undefined:
//    - The rot port is absent.
//    - Shifts always take din.
// TESTING  (WIDTH=8, RESET_VAL=0)
//  - reset=1 mid-cycle -> pout=00, cnt=0, full=0, qout=0 immediately, without waiting for clk.
//  - en=1, mode=01, din=1,0,1,1,0,0,1,0 over 8 clks -> pout=8'h4D, cnt=8, full=1,
//    qout sequence matches din delayed 8 shifts.
//  - mode=11, pin=8'hA5 -> pout=A5, cnt=0, full=0 after 1 clk.
//    Then mode=10, din=0 for 3 clks -> pout=28, qout=q[7]=0, cnt=3.
//  - en=0 with mode=01 for 4 clks after load of 3C -> pout stays 3C, cnt stays 0.
//    A 9th shift after full -> cnt stays 8, data still shifts.
//  - SHIFT_ROTATE_EN: load 81, mode=01, rot=1 for 1 clk -> pout=C0.
//    8 clks total -> pout=81, cnt=8, full=1.

Source files
------------

// File: rtl/universal_shift_reg.sv
// Universal shift register: hold / shift right / shift left / parallel load with a
// saturating shift counter and full flag. Define SHIFT_ROTATE_EN to add the rot port.
module universal_shift_reg #(
   parameter int               WIDTH     = 8,
   parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic [1:0]                 mode,
   input  logic                       din,
   input  logic [WIDTH-1:0]           pin,
`ifdef SHIFT_ROTATE_EN
   input  logic                       rot,
`endif
   output logic                       qout,
   output logic [WIDTH-1:0]           pout,
   output logic [$clog2(WIDTH+1)-1:0] cnt,
   output logic                       full
);

   localparam int            CW      = $clog2(WIDTH+1);
   localparam logic [CW-1:0] CNT_MAX = CW'(WIDTH);

   localparam logic [1:0] MODE_HOLD  = 2'b00;
   localparam logic [1:0] MODE_RIGHT = 2'b01;
   localparam logic [1:0] MODE_LEFT  = 2'b10;
   localparam logic [1:0] MODE_LOAD  = 2'b11;

   typedef enum logic {DIR_RIGHT = 1'b0, DIR_LEFT = 1'b1} dir_e;

   logic [WIDTH-1:0] q_q, q_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             full_q, full_d;
   dir_e             dir_q, dir_d;
   logic             fb_right, fb_left;
   logic [CW-1:0]    cnt_inc;

   // Bit entering the register on a shift: serial input, or the bit leaving the other end.
`ifdef SHIFT_ROTATE_EN
   assign fb_right = rot ? q_q[0]       : din;
   assign fb_left  = rot ? q_q[WIDTH-1] : din;
`else
   assign fb_right = din;
   assign fb_left  = din;
`endif

   assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

   always_comb begin
      q_d   = q_q;
      cnt_d = cnt_q;
      dir_d = dir_q;
      if (en) begin
         case (mode)
            MODE_HOLD: ;
            MODE_RIGHT: begin
               q_d   = {fb_right, q_q[WIDTH-1:1]};
               cnt_d = cnt_inc;
               dir_d = DIR_RIGHT;
            end
            MODE_LEFT: begin
               q_d   = {q_q[WIDTH-2:0], fb_left};
               cnt_d = cnt_inc;
               dir_d = DIR_LEFT;
            end
            MODE_LOAD: begin
               q_d   = pin;
               cnt_d = '0;
            end
            default: ;
         endcase
      end
      full_d = (cnt_d == CNT_MAX);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         q_q    <= RESET_VAL;
         cnt_q  <= '0;
         full_q <= 1'b0;
         dir_q  <= DIR_RIGHT;
      end else begin
         q_q    <= q_d;
         cnt_q  <= cnt_d;
         full_q <= full_d;
         dir_q  <= dir_d;
      end
   end

   assign pout = q_q;
   assign cnt  = cnt_q;
   assign full = full_q;
   assign qout = (dir_q == DIR_LEFT) ? q_q[WIDTH-1] : q_q[0];

endmodule

// File: tb/tb_universal_shift_reg.sv
// Directed bench for universal_shift_reg (WIDTH=8, RESET_VAL=0): a reference model pushes
// expected state to a scoreboard queue on each step; results are popped after the edge.
module tb_universal_shift_reg;

   localparam int W  = 8;
   localparam int CW = $clog2(W+1);
`ifdef SHIFT_ROTATE_EN
   localparam bit ROT_EN = 1'b1;
`else
   localparam bit ROT_EN = 1'b0;
`endif

   typedef struct packed {
      logic [W-1:0]  pout;
      logic [CW-1:0] cnt;
      logic          full;
      logic          qout;
   } exp_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          en;
   logic [1:0]    mode;
   logic          din;
   logic [W-1:0]  pin;
   logic          rot;
   logic          qout;
   logic [W-1:0]  pout;
   logic [CW-1:0] cnt;
   logic          full;

   int total = 0;
   int bad   = 0;

   exp_t sb[$];

   // reference model state
   logic [W-1:0] mq;
   int           mcnt;
   logic         mleft;

   universal_shift_reg #(.WIDTH(W), .RESET_VAL(8'h00)) dut (
      .clk  (clk),
      .reset(reset),
      .en   (en),
      .mode (mode),
      .din  (din),
      .pin  (pin),
`ifdef SHIFT_ROTATE_EN
      .rot  (rot),
`endif
      .qout (qout),
      .pout (pout),
      .cnt  (cnt),
      .full (full)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      total++;
      assert (obs === exp_v) else begin
         bad++;
         $error("FAIL %s: got=%0h want=%0h", tag, obs, exp_v);
      end
   endtask

   function automatic exp_t model_exp();
      exp_t e;
      e.pout = mq;
      e.cnt  = CW'(mcnt);
      e.full = (mcnt == W);
      e.qout = mleft ? mq[W-1] : mq[0];
      return e;
   endfunction

   task automatic model_reset();
      mq = '0; mcnt = 0; mleft = 1'b0;
   endtask

   // drive one cycle of inputs, advance the model, push its expectation, then compare
   task automatic step(input logic e_i, input logic [1:0] m_i, input logic d_i,
                       input logic [W-1:0] p_i, input logic r_i);
      exp_t got, want;
      logic in_bit;
      en = e_i; mode = m_i; din = d_i; pin = p_i; rot = r_i;
      if (e_i) begin
         if (m_i == 2'b01) begin
            in_bit = (ROT_EN && r_i) ? mq[0] : d_i;
            mq = {in_bit, mq[W-1:1]};
            mcnt = (mcnt < W) ? mcnt + 1 : W;
            mleft = 1'b0;
         end else if (m_i == 2'b10) begin
            in_bit = (ROT_EN && r_i) ? mq[W-1] : d_i;
            mq = {mq[W-2:0], in_bit};
            mcnt = (mcnt < W) ? mcnt + 1 : W;
            mleft = 1'b1;
         end else if (m_i == 2'b11) begin
            mq = p_i;
            mcnt = 0;
         end
      end
      sb.push_back(model_exp());
      @(posedge clk);
      #1;
      got = '{pout: pout, cnt: cnt, full: full, qout: qout};
      if (sb.size() == 0) begin
         check("sb_empty", 32'd1, 32'd0);
      end else begin
         want = sb.pop_front();
         check("pout", 32'(got.pout), 32'(want.pout));
         check("cnt",  32'(got.cnt),  32'(want.cnt));
         check("full", 32'(got.full), 32'(want.full));
         check("qout", 32'(got.qout), 32'(want.qout));
      end
   endtask

   initial begin
      logic [7:0] seq;
      reset = 1'b1; en = 1'b0; mode = 2'b00; din = 1'b0; pin = '0; rot = 1'b0;
      model_reset();
      #12;
      check("rst_pout", 32'(pout), 32'h00);
      check("rst_cnt",  32'(cnt),  32'd0);
      check("rst_full", 32'(full), 32'd0);
      check("rst_qout", 32'(qout), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk); #1;

      // right shifts: din 1,0,1,1,0,0,1,0
      seq = 8'b0100_1101;
      for (int i = 0; i < 8; i++) step(1'b1, 2'b01, seq[i], '0, 1'b0);
      check("sipo_4d",  32'(pout), 32'h4D);
      check("sipo_cnt", 32'(cnt),  32'd8);
      check("sipo_full",32'(full), 32'd1);
      check("sipo_qout",32'(qout), 32'd1);

      // load A5 then left shift zeros x3
      step(1'b1, 2'b11, 1'b0, 8'hA5, 1'b0);
      check("load_a5", 32'(pout), 32'hA5);
      for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b0, '0, 1'b0);
      check("left_28",  32'(pout), 32'h28);
      check("left_cnt", 32'(cnt),  32'd3);

      // direction change mid-word keeps counting; mode 00 holds
      step(1'b1, 2'b01, 1'b1, '0, 1'b0);
      step(1'b1, 2'b01, 1'b1, '0, 1'b0);
      step(1'b1, 2'b00, 1'b0, 8'hFF, 1'b0);
      check("dirchg_cnt", 32'(cnt), 32'd5);

      // load 3C then en=0 with mode=01 holds
      step(1'b1, 2'b11, 1'b0, 8'h3C, 1'b0);
      for (int i = 0; i < 4; i++) step(1'b0, 2'b01, 1'b1, 8'hFF, 1'b0);
      check("en0_pout", 32'(pout), 32'h3C);
      check("en0_cnt",  32'(cnt),  32'd0);

      // 9 shifts: saturation at 8, data keeps moving
      for (int i = 0; i < 9; i++) step(1'b1, 2'b10, i[0], '0, 1'b0);
      check("sat_cnt",  32'(cnt),  32'd8);
      check("sat_full", 32'(full), 32'd1);

      if (ROT_EN) begin
         step(1'b1, 2'b11, 1'b0, 8'h81, 1'b0);
         step(1'b1, 2'b01, 1'b0, '0, 1'b1);
         check("rot_c0", 32'(pout), 32'hC0);
         for (int i = 0; i < 7; i++) step(1'b1, 2'b01, 1'b0, '0, 1'b1);
         check("rot_81",   32'(pout), 32'h81);
         check("rot_full", 32'(full), 32'd1);
         for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b1, '0, 1'b1);
      end else begin
         // rot has no effect without the rotate option
         for (int i = 0; i < 3; i++) step(1'b1, 2'b01, 1'b0, '0, 1'b1);
      end

      // random mix
      for (int i = 0; i < 40; i++)
         step(1'($urandom_range(0, 5) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
              8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));

      // reset asserted mid-cycle, no clock edge needed
      for (int i = 0; i < 3; i++) step(1'b1, 2'b10, 1'b1, '0, 1'b0);
      #2;
      reset = 1'b1;
      model_reset();
      #1;
      check("mid_rst_pout", 32'(pout), 32'h00);
      check("mid_rst_cnt",  32'(cnt),  32'd0);
      check("mid_rst_full", 32'(full), 32'd0);
      check("mid_rst_qout", 32'(qout), 32'd0);
      @(negedge clk);
      reset = 1'b0;
      step(1'b1, 2'b01, 1'b1, '0, 1'b0);
      check("post_rst_pout", 32'(pout), 32'h80);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
